// File: rtl/cmd_decoder.sv
// Command execution stage: decodes W/R triplets from the UART collector, drives
// the register-file port and emits one OK/DATA/ERR response pulse per command.
module cmd_decoder #(
  parameter int         NUM_REGS        = 16,
  parameter int         REG_AW          = 4,
  parameter logic [7:0] CMD_WRITE       = 8'h57,
  parameter logic [7:0] CMD_READ        = 8'h52,
  parameter logic [7:0] ERR_UNKNOWN_CMD = 8'h01,
  parameter logic [7:0] ERR_BAD_ADDR    = 8'h02
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_ready,
  input  logic [7:0]        cmd,
  input  logic [7:0]        addr,
  input  logic [7:0]        data,
  input  logic [7:0]        reg_rd_data,
  output logic              reg_wr_en,
  output logic [REG_AW-1:0] reg_addr,
  output logic [7:0]        reg_wr_data,
  output logic              resp_ok,
  output logic              resp_data,
  output logic              resp_err,
  output logic [7:0]        resp_addr,
  output logic [7:0]        resp_data_byte,
  output logic [7:0]        resp_err_code
);

  typedef enum logic [1:0] {IDLE, DECODE, READ} state_t;

  state_t             state, state_n;
  logic [7:0]         cmd_q, addr_q, data_q;
  logic [7:0]         cmd_n, addr_n, data_n;
  logic               reg_wr_en_n, resp_ok_n, resp_data_n, resp_err_n;
  logic [REG_AW-1:0]  reg_addr_n;
  logic [7:0]         reg_wr_data_n, resp_addr_n, resp_data_byte_n, resp_err_code_n;
  logic               addr_bad;

  // Any bit above the register index means the address is out of range.
  assign addr_bad = |addr_q[7:REG_AW];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state          <= IDLE;
      cmd_q          <= '0;
      addr_q         <= '0;
      data_q         <= '0;
      reg_wr_en      <= 1'b0;
      reg_addr       <= '0;
      reg_wr_data    <= '0;
      resp_ok        <= 1'b0;
      resp_data      <= 1'b0;
      resp_err       <= 1'b0;
      resp_addr      <= '0;
      resp_data_byte <= '0;
      resp_err_code  <= '0;
    end else begin
      state          <= state_n;
      cmd_q          <= cmd_n;
      addr_q         <= addr_n;
      data_q         <= data_n;
      reg_wr_en      <= reg_wr_en_n;
      reg_addr       <= reg_addr_n;
      reg_wr_data    <= reg_wr_data_n;
      resp_ok        <= resp_ok_n;
      resp_data      <= resp_data_n;
      resp_err       <= resp_err_n;
      resp_addr      <= resp_addr_n;
      resp_data_byte <= resp_data_byte_n;
      resp_err_code  <= resp_err_code_n;
    end
  end

  always_comb begin
    state_n          = state;
    cmd_n            = cmd_q;
    addr_n           = addr_q;
    data_n           = data_q;
    reg_wr_en_n      = 1'b0;
    resp_ok_n        = 1'b0;
    resp_data_n      = 1'b0;
    resp_err_n       = 1'b0;
    reg_addr_n       = reg_addr;
    reg_wr_data_n    = reg_wr_data;
    resp_addr_n      = resp_addr;
    resp_data_byte_n = resp_data_byte;
    resp_err_code_n  = resp_err_code;
    case (state)
      IDLE: begin
        if (cmd_ready) begin
          cmd_n   = cmd;
          addr_n  = addr;
          data_n  = data;
          state_n = DECODE;
        end
      end
      DECODE: begin
        resp_addr_n = addr_q;
        state_n     = IDLE;
        if (cmd_q != CMD_WRITE && cmd_q != CMD_READ) begin
          resp_err_n      = 1'b1;
          resp_err_code_n = ERR_UNKNOWN_CMD;
        end else if (addr_bad) begin
          resp_err_n      = 1'b1;
          resp_err_code_n = ERR_BAD_ADDR;
        end else if (cmd_q == CMD_WRITE) begin
          reg_wr_en_n   = 1'b1;
          reg_addr_n    = addr_q[REG_AW-1:0];
          reg_wr_data_n = data_q;
          resp_ok_n     = 1'b1;
        end else begin
          // Present the address now; the file's combinational read settles for READ.
          reg_addr_n = addr_q[REG_AW-1:0];
          state_n    = READ;
        end
      end
      READ: begin
        resp_data_byte_n = reg_rd_data;
        resp_data_n      = 1'b1;
        state_n          = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_cmd_decoder.sv
// Directed bench for cmd_decoder: drives on negedge, checks on following negedges.
module tb_cmd_decoder;
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       cmd_ready = 1'b0;
  logic [7:0] cmd = '0, addr = '0, data = '0, reg_rd_data = '0;
  logic       reg_wr_en, resp_ok, resp_data, resp_err;
  logic [3:0] reg_addr;
  logic [7:0] reg_wr_data, resp_addr, resp_data_byte, resp_err_code;

  int n_chk = 0;
  int n_fail = 0;

  cmd_decoder dut (
    .clk(clk), .rst(rst), .cmd_ready(cmd_ready), .cmd(cmd), .addr(addr), .data(data),
    .reg_rd_data(reg_rd_data), .reg_wr_en(reg_wr_en), .reg_addr(reg_addr),
    .reg_wr_data(reg_wr_data), .resp_ok(resp_ok), .resp_data(resp_data),
    .resp_err(resp_err), .resp_addr(resp_addr), .resp_data_byte(resp_data_byte),
    .resp_err_code(resp_err_code)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  // Returns at the negedge after the accepting posedge (state = DECODE).
  task automatic send(input logic [7:0] c, input logic [7:0] a, input logic [7:0] d);
    @(negedge clk);
    cmd = c; addr = a; data = d; cmd_ready = 1'b1;
    @(negedge clk);
    cmd_ready = 1'b0;
  endtask

  task automatic pulses_low(input string tag);
    chk({tag, "_ok"},  resp_ok,   1'b0);
    chk({tag, "_dat"}, resp_data, 1'b0);
    chk({tag, "_err"}, resp_err,  1'b0);
    chk({tag, "_wr"},  reg_wr_en, 1'b0);
  endtask

  initial begin
    #12;
    chk("rst_pulses", {reg_wr_en, resp_ok, resp_data, resp_err}, 4'b0);
    chk("rst_fields", {reg_addr, reg_wr_data, resp_addr, resp_data_byte, resp_err_code}, 36'h0);
    @(negedge clk); rst = 1'b1;

    // valid write
    send(8'h57, 8'h03, 8'hB3);
    chk("w_early_ok", resp_ok, 1'b0);
    @(negedge clk);
    chk("w_wr_en", reg_wr_en, 1'b1);
    chk("w_addr", reg_addr, 4'h3);
    chk("w_wdata", reg_wr_data, 8'hB3);
    chk("w_ok", resp_ok, 1'b1);
    chk("w_raddr", resp_addr, 8'h03);
    chk("w_err", resp_err, 1'b0);
    @(negedge clk);
    pulses_low("w_after");

    // valid read: pulse one edge later than write
    reg_rd_data = 8'h5A;
    send(8'h52, 8'h03, 8'h00);
    @(negedge clk);
    chk("r_early", resp_data, 1'b0);
    chk("r_wr0", reg_wr_en, 1'b0);
    chk("r_addr", reg_addr, 4'h3);
    @(negedge clk);
    chk("r_dat", resp_data, 1'b1);
    chk("r_raddr", resp_addr, 8'h03);
    chk("r_byte", resp_data_byte, 8'h5A);
    chk("r_wr1", reg_wr_en, 1'b0);
    chk("r_ok", resp_ok, 1'b0);
    @(negedge clk);
    pulses_low("r_after");

    // bad address write
    send(8'h57, 8'h10, 8'hAA);
    @(negedge clk);
    chk("ba_err", resp_err, 1'b1);
    chk("ba_code", resp_err_code, 8'h02);
    chk("ba_wr", reg_wr_en, 1'b0);
    chk("ba_ok", resp_ok, 1'b0);
    chk("ba_raddr", resp_addr, 8'h10);
    chk("ba_hold_addr", reg_addr, 4'h3);
    @(negedge clk);
    pulses_low("ba_after");

    // unknown opcode, then unknown opcode with bad address (precedence)
    send(8'h99, 8'h02, 8'h11);
    @(negedge clk);
    chk("uk_err", resp_err, 1'b1);
    chk("uk_code", resp_err_code, 8'h01);
    chk("uk_raddr", resp_addr, 8'h02);
    send(8'h99, 8'h20, 8'h00);
    @(negedge clk);
    chk("ukb_err", resp_err, 1'b1);
    chk("ukb_code", resp_err_code, 8'h01);
    chk("ukb_wr", reg_wr_en, 1'b0);

    // lowercase opcode is unknown
    send(8'h77, 8'h01, 8'h00);
    @(negedge clk);
    chk("lc_err", resp_err, 1'b1);
    chk("lc_code", resp_err_code, 8'h01);
    chk("lc_wr", reg_wr_en, 1'b0);

    // boundaries
    send(8'h57, 8'h0F, 8'h55);
    @(negedge clk);
    chk("bw_ok", resp_ok, 1'b1);
    chk("bw_addr", reg_addr, 4'hF);
    chk("bw_wdata", reg_wr_data, 8'h55);
    send(8'h52, 8'hFF, 8'h00);
    @(negedge clk);
    chk("br_err", resp_err, 1'b1);
    chk("br_code", resp_err_code, 8'h02);
    chk("br_raddr", resp_addr, 8'hFF);
    chk("br_hold_addr", reg_addr, 4'hF);
    @(negedge clk);
    chk("br_nodat", resp_data, 1'b0);

    // cmd_ready while in DECODE is dropped
    send(8'h57, 8'h05, 8'h11);
    cmd = 8'h52; addr = 8'h06; cmd_ready = 1'b1;
    @(negedge clk);
    cmd_ready = 1'b0;
    chk("bz_ok", resp_ok, 1'b1);
    chk("bz_raddr", resp_addr, 8'h05);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      pulses_low("bz_quiet");
    end
    chk("bz_hold_raddr", resp_addr, 8'h05);

    // reset during READ aborts the command
    reg_rd_data = 8'hC3;
    send(8'h52, 8'h07, 8'h00);
    @(negedge clk);
    chk("rr_in_read_addr", reg_addr, 4'h7);
    rst = 1'b0;
    #1;
    chk("rr_pulses", {reg_wr_en, resp_ok, resp_data, resp_err}, 4'b0);
    chk("rr_fields", {reg_addr, reg_wr_data, resp_addr, resp_data_byte, resp_err_code}, 36'h0);
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rr_nodat", resp_data, 1'b0);
    end

    // recovery after reset
    send(8'h52, 8'h07, 8'h00);
    @(negedge clk);
    @(negedge clk);
    chk("rc_dat", resp_data, 1'b1);
    chk("rc_byte", resp_data_byte, 8'hC3);
    chk("rc_raddr", resp_addr, 8'h07);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no end, expected finish");
    $fatal(1);
  end
endmodule

// File: doc/cmd_decoder.md
Name: cmd_decoder

Overview:
Command execution stage between the UART command collector and the 16-entry register file. It accepts a complete (cmd, addr, data) triplet on a one-cycle `cmd_ready` pulse. It decodes WRITE ('W') and READ ('R') commands, drives the register-file write/read port, and emits exactly one one-cycle response pulse per command: OK, DATA or ERR. Response fields feed the downstream response formatter/UART TX path.

Parameters:
NUM_REGS, 16, number of addressable registers; valid addresses are 0..NUM_REGS-1.
REG_AW, 4, register-file address width (log2 NUM_REGS).
CMD_WRITE, 8'h57, opcode for write ('W').
CMD_READ, 8'h52, opcode for read ('R').
ERR_UNKNOWN_CMD, 8'h01, error code for an unrecognised opcode.
ERR_BAD_ADDR, 8'h02, error code for address >= NUM_REGS.

Ports:
clk  in  1  system clock, all state on rising edge
rst  in  1  asynchronous, active-low reset
cmd_ready  in  1  one-cycle pulse; cmd/addr/data valid this cycle
cmd  in  8  opcode byte
addr  in  8  register address byte
data  in  8  write data byte (ignored for READ)
reg_rd_data  in  8  register-file read data for reg_addr (combinational read)
reg_wr_en  out  1  one-cycle register-file write strobe
reg_addr  out  REG_AW  register-file address
reg_wr_data  out  8  register-file write data
resp_ok  out  1  one-cycle pulse: write completed
resp_data  out  1  one-cycle pulse: read data valid
resp_err  out  1  one-cycle pulse: command rejected
resp_addr  out  8  full 8-bit address of the command being answered
resp_data_byte  out  8  read data (valid with resp_data)
resp_err_code  out  8  error code (valid with resp_err)

Behaviour:
- Reset (rst low, asynchronous): all outputs 0; internal latches 0; FSM in IDLE.
- All outputs are registered; reg_wr_en, resp_ok, resp_data and resp_err default to 0 every cycle, so each is a pulse exactly one cycle wide.
- reg_addr, reg_wr_data, resp_addr, resp_data_byte and resp_err_code hold their last value until overwritten.
- FSM has three states: IDLE, DECODE, READ.
- IDLE: on a posedge with cmd_ready=1, latch cmd, addr and data into cmd_q, addr_q and data_q, then go to DECODE. cmd_ready outside IDLE is ignored; commands are not queued.
- DECODE is a single cycle. Decode precedence:
  - 1) cmd_q not CMD_WRITE and not CMD_READ: resp_err<=1, resp_err_code<=ERR_UNKNOWN_CMD. The unknown-opcode check wins even if the address is also bad.
  - 2) addr_q >= NUM_REGS (any of addr_q[7:REG_AW] set): resp_err<=1, resp_err_code<=ERR_BAD_ADDR. No reg_wr_en is issued.
  - 3) Valid WRITE: reg_wr_en<=1, reg_addr<=addr_q[REG_AW-1:0], reg_wr_data<=data_q and resp_ok<=1, all in the same cycle.
  - 4) Valid READ: reg_addr<=addr_q[REG_AW-1:0], then go to READ.
  - Error and write outcomes return to IDLE. All outcomes set resp_addr<=addr_q.
- READ is a single cycle. With reg_addr already stable, set resp_data_byte<=reg_rd_data and resp_data<=1, then return to IDLE.
- Latency from the clock edge that samples cmd_ready:
  - WRITE/ERR pulses are visible after 2 edges.
  - READ pulse is visible after 3 edges.
- A new command may be accepted in the cycle the response pulse is high, because the FSM is back in IDLE.
- Opcodes are case-sensitive; lowercase 'w'/'r' are unknown commands. The data byte is ignored for READ and for errors.
- Reset asserted mid-command aborts the command; no response pulse is produced.

Test Plan:
- WRITE valid: send W/0x03/0xB3 -> one cycle with reg_wr_en=1, reg_addr=3, reg_wr_data=B3 and resp_ok=1 together; resp_ok=0 on the next cycle.
- READ valid: set reg_rd_data=0x5A, send R/0x03/0x00 -> one cycle with resp_data=1, resp_addr=03, resp_data_byte=5A; reg_wr_en never asserted; resp_data=0 on the next cycle.
- BAD address: send W/0x10/0xAA -> one-cycle resp_err with resp_err_code=02; no reg_wr_en.
- UNKNOWN cmd: send 0x99/0x02/0x11 -> one-cycle resp_err with code=01. Also send 0x99/0x20 -> code=01 (precedence check).
- Boundary: W/0x0F/0x55 -> OK with reg_addr=F. R/0xFF -> ERR 02.
- Busy/reset: pulse cmd_ready again while in DECODE -> ignored, exactly one response. Drop rst mid-READ -> all outputs 0 immediately, no resp_data.
